// File: rtl/calc_seq_ctrl.sv
// rtl/calc_seq_ctrl.sv - operand-selection and compute sequencer for calculation mode
// Walks opcode, per-operand m/n/list/ID entry, storage read and compute, with timeout and back-step.
module calc_seq_ctrl #(
  parameter int NOPND_MAX = 3,
  parameter int OPC_W = 4,
  parameter int VAL_W = 3,
  parameter logic [(2<<OPC_W)-1:0] ARITY_MAP = 32'h0000_0088,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             confirm,
  input  logic             back,
  input  logic [OPC_W-1:0] sw_op,
  input  logic [VAL_W-1:0] sw_val,
  input  logic             list_done,
  input  logic             rd_ack,
  input  logic             operand_legal,
  input  logic             compute_done,
  output logic [3:0]       state_o,
  output logic [OPC_W-1:0] op_type,
  output logic [1:0]       opnd_idx,
  output logic             opnd_we,
  output logic [VAL_W-1:0] opnd_m,
  output logic [VAL_W-1:0] opnd_n,
  output logic [VAL_W-1:0] opnd_id,
  output logic             list_req,
  output logic             rd_req,
  output logic             start_compute,
  output logic             err,
  output logic             busy
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_OP    = 4'd1,
    S_DIM_M = 4'd2,
    S_DIM_N = 4'd3,
    S_LIST  = 4'd4,
    S_ID    = 4'd5,
    S_WAIT  = 4'd6,
    S_CHECK = 4'd7,
    S_EXEC  = 4'd8,
    S_ERROR = 4'd9
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       arity, arity_n, arity_sel;
  logic [1:0]       idx, idx_n, opnd_idx_n;
  logic [OPC_W-1:0] op_type_n;
  logic [VAL_W-1:0] opnd_m_n, opnd_n_n, opnd_id_n;
  logic             opnd_we_n, list_req_n, rd_req_n, start_compute_n;
  logic             timed, timeout;

  assign arity_sel = ARITY_MAP[{sw_op, 1'b0} +: 2];
  assign timed     = (state == S_OP) || (state == S_DIM_M) || (state == S_DIM_N) ||
                     (state == S_ID) || (state == S_ERROR);
  assign timeout   = timed && (cnt == CNT_W'(1));
  assign state_o   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= CNT_LOAD;
      arity         <= '0;
      idx           <= '0;
      op_type       <= '0;
      opnd_idx      <= '0;
      opnd_m        <= '0;
      opnd_n        <= '0;
      opnd_id       <= '0;
      opnd_we       <= 1'b0;
      list_req      <= 1'b0;
      rd_req        <= 1'b0;
      start_compute <= 1'b0;
      err           <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      arity         <= arity_n;
      idx           <= idx_n;
      op_type       <= op_type_n;
      opnd_idx      <= opnd_idx_n;
      opnd_m        <= opnd_m_n;
      opnd_n        <= opnd_n_n;
      opnd_id       <= opnd_id_n;
      opnd_we       <= opnd_we_n;
      list_req      <= list_req_n;
      rd_req        <= rd_req_n;
      start_compute <= start_compute_n;
      err           <= (state_n == S_ERROR);
      busy          <= (state_n != S_IDLE);
    end
  end

  always_comb begin
    state_n         = state;
    arity_n         = arity;
    idx_n           = idx;
    op_type_n       = op_type;
    opnd_m_n        = opnd_m;
    opnd_n_n        = opnd_n;
    opnd_id_n       = opnd_id;
    opnd_we_n       = 1'b0;
    list_req_n      = 1'b0;
    rd_req_n        = 1'b0;
    start_compute_n = 1'b0;

    if (timeout) begin
      state_n = S_IDLE;
    end else if (back && ((state == S_OP) || (state == S_DIM_M) ||
                          (state == S_DIM_N) || (state == S_ID))) begin
      case (state)
        S_OP:    state_n = S_IDLE;
        S_DIM_M: begin
          if (idx != 2'd0) begin
            idx_n   = idx - 2'd1;
            state_n = S_ID;
          end else begin
            state_n = S_OP;
          end
        end
        S_DIM_N: state_n = S_DIM_M;
        default: state_n = S_DIM_N;
      endcase
    end else begin
      case (state)
        S_IDLE: if (start) state_n = S_OP;
        S_OP: begin
          if (confirm) begin
            op_type_n = sw_op;
            arity_n   = arity_sel;
            idx_n     = 2'd0;
            state_n   = ((arity_sel == 2'd0) || (int'(arity_sel) > NOPND_MAX)) ? S_ERROR : S_DIM_M;
          end
        end
        S_DIM_M: begin
          if (confirm && (sw_val != '0)) begin
            opnd_m_n = sw_val;
            state_n  = S_DIM_N;
          end
        end
        S_DIM_N: begin
          if (confirm && (sw_val != '0)) begin
            opnd_n_n   = sw_val;
            list_req_n = 1'b1;
            state_n    = S_LIST;
          end
        end
        S_LIST: if (list_done) state_n = S_ID;
        S_ID: begin
          if (confirm) begin
            opnd_id_n = sw_val;
            opnd_we_n = 1'b1;
            if (({1'b0, idx} + 3'd1) < {1'b0, arity}) begin
              idx_n   = idx + 2'd1;
              state_n = S_DIM_M;
            end else begin
              rd_req_n = 1'b1;
              state_n  = S_WAIT;
            end
          end
        end
        S_WAIT: if (rd_ack) state_n = S_CHECK;
        S_CHECK: begin
          start_compute_n = operand_legal;
          state_n         = operand_legal ? S_EXEC : S_ERROR;
        end
        S_EXEC:  if (compute_done) state_n = S_IDLE;
        S_ERROR: if (confirm) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end

    // The write cycle shows the index just written; the advanced index appears a cycle later.
    opnd_idx_n = opnd_we_n ? idx : idx_n;

    if ((state_n != state) || confirm || back) begin
      cnt_n = CNT_LOAD;
    end else if (timed) begin
      cnt_n = cnt - CNT_W'(1);
    end else begin
      cnt_n = cnt;
    end
  end
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb/tb_calc_seq_ctrl.sv - bench for calc_seq_ctrl
// Cycle model compared every cycle, plus directed literal expectations.
module tb_calc_seq_ctrl;
  localparam int TMO = 8;
  localparam int NMAX = 2;
  localparam logic [31:0] MAP = 32'h5555_5789;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, confirm = 1'b0, back = 1'b0;
  logic [3:0] sw_op = '0;
  logic [2:0] sw_val = '0;
  logic list_done = 1'b0, rd_ack = 1'b0, operand_legal = 1'b0, compute_done = 1'b0;
  logic [3:0] state_o, op_type;
  logic [1:0] opnd_idx;
  logic opnd_we, list_req, rd_req, start_compute, err, busy;
  logic [2:0] opnd_m, opnd_n, opnd_id;

  int n_checks = 0;
  int n_errors = 0;
  int n_we = 0, n_sc = 0, n_rd = 0, n_list = 0;
  logic [10:0] wr_q[$];

  calc_seq_ctrl #(
    .NOPND_MAX(NMAX), .OPC_W(4), .VAL_W(3), .ARITY_MAP(MAP), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .confirm(confirm), .back(back),
    .sw_op(sw_op), .sw_val(sw_val), .list_done(list_done), .rd_ack(rd_ack),
    .operand_legal(operand_legal), .compute_done(compute_done), .state_o(state_o),
    .op_type(op_type), .opnd_idx(opnd_idx), .opnd_we(opnd_we), .opnd_m(opnd_m),
    .opnd_n(opnd_n), .opnd_id(opnd_id), .list_req(list_req), .rd_req(rd_req),
    .start_compute(start_compute), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int st; int ar; int idx; int idx_out; int age; int op; int mv; int nv; int idv;
    bit we; bit list; bit rd; bit sc;
  } mdl_t;
  mdl_t m;

  function automatic bit timed_st(input int s);
    return (s == 1) || (s == 2) || (s == 3) || (s == 5) || (s == 9);
  endfunction

  function automatic mdl_t model_next(input mdl_t c);
    mdl_t n;
    n = c;
    n.we = 1'b0; n.list = 1'b0; n.rd = 1'b0; n.sc = 1'b0;
    if (timed_st(c.st) && (c.age + 1 >= TMO)) n.st = 0;
    else if (back && (c.st == 1 || c.st == 2 || c.st == 3 || c.st == 5)) begin
      if (c.st == 1) n.st = 0;
      else if (c.st == 2) begin
        if (c.idx > 0) begin n.idx = c.idx - 1; n.st = 5; end
        else n.st = 1;
      end else if (c.st == 3) n.st = 2;
      else n.st = 3;
    end else begin
      case (c.st)
        0: if (start) n.st = 1;
        1: if (confirm) begin
          n.op = int'(sw_op);
          n.ar = int'((MAP >> (2 * int'(sw_op))) & 32'd3);
          n.idx = 0;
          n.st = (n.ar >= 1 && n.ar <= NMAX) ? 2 : 9;
        end
        2: if (confirm && sw_val != 0) begin n.mv = int'(sw_val); n.st = 3; end
        3: if (confirm && sw_val != 0) begin n.nv = int'(sw_val); n.st = 4; n.list = 1'b1; end
        4: if (list_done) n.st = 5;
        5: if (confirm) begin
          n.idv = int'(sw_val);
          n.we = 1'b1;
          if (c.idx + 1 < c.ar) begin n.idx = c.idx + 1; n.st = 2; end
          else begin n.st = 6; n.rd = 1'b1; end
        end
        6: if (rd_ack) n.st = 7;
        7: begin n.st = operand_legal ? 8 : 9; n.sc = operand_legal; end
        8: if (compute_done) n.st = 0;
        9: if (confirm) n.st = 0;
        default: n.st = 0;
      endcase
    end
    n.idx_out = n.we ? c.idx : n.idx;
    n.age = (n.st != c.st || confirm || back) ? 0 : (timed_st(c.st) ? c.age + 1 : c.age);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= model_next(m);
  end

  function automatic logic [24:0] dut_vec();
    return {state_o, op_type, opnd_idx, opnd_we, opnd_m, opnd_n, opnd_id,
            list_req, rd_req, start_compute, err, busy};
  endfunction

  function automatic logic [24:0] mdl_vec(input mdl_t c);
    return {4'(c.st), 4'(c.op), 2'(c.idx_out), c.we, 3'(c.mv), 3'(c.nv), 3'(c.idv),
            c.list, c.rd, c.sc, (c.st == 9), (c.st != 0)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("cycle_outputs", 32'(dut_vec()), 32'(mdl_vec(m)));
    if (opnd_we === 1'b1) begin
      n_we++;
      wr_q.push_back({opnd_idx, opnd_m, opnd_n, opnd_id});
    end
    if (start_compute === 1'b1) n_sc++;
    if (rd_req === 1'b1) n_rd++;
    if (list_req === 1'b1) n_list++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0; confirm = 1'b0; back = 1'b0;
    list_done = 1'b0; rd_ack = 1'b0; compute_done = 1'b0;
  endtask

  task automatic do_confirm(input logic [2:0] v);
    sw_val = v; confirm = 1'b1; step();
  endtask

  task automatic clear_counts();
    n_we = 0; n_sc = 0; n_rd = 0; n_list = 0;
    wr_q.delete();
  endtask

  task automatic count_in(input logic [3:0] s, input int first, output int n);
    n = first;
    for (int i = 0; i < 40; i++) begin
      step();
      if (state_o == s) n++;
      else break;
    end
  endtask

  int cyc;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(dut_vec()), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", {28'd0, state_o}, 32'd0);

    // Unary opcode 0
    clear_counts();
    start = 1'b1; step();
    chk("start_to_op", {28'd0, state_o}, 32'd1);
    sw_op = 4'd0; confirm = 1'b1; step();
    chk("op0_to_dim_m", {28'd0, state_o}, 32'd2);
    start = 1'b1; step();
    chk("start_ignored", {28'd0, state_o}, 32'd2);
    do_confirm(3'd0);
    chk("zero_m_stays", {28'd0, state_o}, 32'd2);
    do_confirm(3'd2);
    do_confirm(3'd3);
    chk("list_entry", {27'd0, state_o, list_req}, {27'd0, 4'd4, 1'b1});
    repeat (2) step();
    list_done = 1'b1; step();
    operand_legal = 1'b1;
    do_confirm(3'd5);
    chk("unary_write", {20'd0, opnd_we, opnd_idx, opnd_m, opnd_n, opnd_id, rd_req},
        {20'd0, 1'b1, 2'd0, 3'd2, 3'd3, 3'd5, 1'b1});
    step();
    rd_ack = 1'b1; step();
    chk("check_state", {28'd0, state_o}, 32'd7);
    step();
    chk("exec_pulse", {27'd0, state_o, start_compute}, {27'd0, 4'd8, 1'b1});
    chk("mdl_exec_state", m.st, 32'd8);
    step();
    chk("exec_pulse_single", {31'd0, start_compute}, 32'd0);
    compute_done = 1'b1; step();
    chk("exec_to_idle", {28'd0, state_o}, 32'd0);
    chk("unary_we_count", n_we, 32'd1);
    chk("unary_we_data", {21'd0, wr_q[0]}, {21'd0, 2'd0, 3'd2, 3'd3, 3'd5});
    chk("unary_pulse_counts", {n_sc[7:0], n_rd[7:0], n_list[7:0]}, {8'd1, 8'd1, 8'd1});

    // Binary opcode 3 with back-steps, illegal result
    clear_counts();
    operand_legal = 1'b0;
    start = 1'b1; step();
    sw_op = 4'd3; confirm = 1'b1; step();
    do_confirm(3'd1);
    back = 1'b1; step();
    chk("back_dim_n", {28'd0, state_o}, 32'd2);
    do_confirm(3'd1);
    do_confirm(3'd2);
    list_done = 1'b1; step();
    do_confirm(3'd3);
    chk("we_idx0", {25'd0, opnd_we, opnd_idx, state_o}, {25'd0, 1'b1, 2'd0, 4'd2});
    step();
    chk("idx_advanced", {29'd0, opnd_we, opnd_idx}, {29'd0, 1'b0, 2'd1});
    back = 1'b1; step();
    chk("back_to_prev_id", {26'd0, state_o, opnd_idx}, {26'd0, 4'd5, 2'd0});
    do_confirm(3'd3);
    do_confirm(3'd4);
    do_confirm(3'd5);
    list_done = 1'b1; step();
    do_confirm(3'd6);
    chk("we_idx1", {29'd0, opnd_we, opnd_idx}, {29'd0, 1'b1, 2'd1});
    rd_ack = 1'b1; step();
    step();
    chk("illegal_error", {27'd0, state_o, err}, {27'd0, 4'd9, 1'b1});
    confirm = 1'b1; step();
    chk("error_confirm_idle", {27'd0, state_o, err}, 32'd0);
    chk("binary_we_count", n_we, 32'd3);
    chk("binary_we_first", {21'd0, wr_q[0]}, {21'd0, 2'd0, 3'd1, 3'd2, 3'd3});
    chk("binary_we_last", {21'd0, wr_q[2]}, {21'd0, 2'd1, 3'd4, 3'd5, 3'd6});
    chk("binary_no_compute", n_sc, 32'd0);

    // Opcode 2: arity 0, then ERROR times out
    start = 1'b1; step();
    sw_op = 4'd2; confirm = 1'b1; step();
    chk("arity0_error", {27'd0, state_o, err}, {27'd0, 4'd9, 1'b1});
    chk("mdl_err_state", m.st, 32'd9);
    count_in(4'd9, 1, cyc);
    chk("error_timeout_cycles", cyc, 32'(TMO));

    // Opcode 4: arity 3 exceeds the operand limit
    start = 1'b1; step();
    sw_op = 4'd4; confirm = 1'b1; step();
    chk("arity_over_max", {28'd0, state_o}, 32'd9);
    confirm = 1'b1; step();

    // back at OP
    start = 1'b1; step();
    back = 1'b1; step();
    chk("back_op_idle", {28'd0, state_o}, 32'd0);

    // Timeout in DIM_N, plain and with a reload at cycle 7
    start = 1'b1; step();
    sw_op = 4'd5; confirm = 1'b1; step();
    do_confirm(3'd1);
    count_in(4'd3, 1, cyc);
    chk("dim_n_timeout", cyc, 32'(TMO));
    chk("timeout_idle", {28'd0, state_o}, 32'd0);
    start = 1'b1; step();
    confirm = 1'b1; step();
    do_confirm(3'd1);
    repeat (6) step();
    do_confirm(3'd0);
    count_in(4'd3, 8, cyc);
    chk("dim_n_reload", cyc, 32'(TMO + 7));

    // Reset while in EXEC
    operand_legal = 1'b1;
    start = 1'b1; step();
    confirm = 1'b1; step();
    do_confirm(3'd1);
    do_confirm(3'd1);
    list_done = 1'b1; step();
    do_confirm(3'd1);
    rd_ack = 1'b1; step();
    step();
    chk("reach_exec", {27'd0, state_o, start_compute}, {27'd0, 4'd8, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 32'(dut_vec()), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_edge_outputs", 32'(dut_vec()), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", {28'd0, state_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
